// File: rtl/max_product_window_sched.sv
// max_product_window_sched: walks a block one window at a time through metric fetch, datapath issue and LLR write-back
module max_product_window_sched #(
  parameter int SYMBOLS     = 4,
  parameter int MAX_WINDOWS = 256,
  parameter int WIN_BITS    = 8,
  parameter int LEN_BITS    = 11,
  parameter int MAX_LATENCY = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [LEN_BITS-1:0]        block_len,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       mem_rd_en,
  output logic [WIN_BITS-1:0]        mem_rd_addr,
  input  logic                       mem_rd_valid,
  output logic                       stage_load,
  output logic                       mp_in_valid,
  input  logic                       mp_out_valid,
  output logic                       llr_wr_en,
  output logic [WIN_BITS-1:0]        llr_wr_addr,
  output logic [$clog2(SYMBOLS):0]   valid_syms
);
  localparam int VS_W  = $clog2(SYMBOLS) + 1;
  localparam int CNT_W = $clog2(MAX_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, ISSUE, WAIT_RESULT, WRITE, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [WIN_BITS-1:0] win_q, win_d, last_win_q, last_win_d, addr_q, addr_d;
  logic [VS_W-1:0] last_syms_q, last_syms_d, vs_q, vs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_BITS:0] len_ext, nwin;
  logic error_q, error_d, busy_q, busy_d, done_q, done_d;
  logic rd_en_q, rd_en_d, iss_q, iss_d, wr_en_q, wr_en_d;
  assign len_ext = {1'b0, block_len};
  assign nwin    = (len_ext + (LEN_BITS+1)'(SYMBOLS - 1)) / (LEN_BITS+1)'(SYMBOLS);
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_win_d  = last_win_q;
    last_syms_d = last_syms_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    case (state_q)
      IDLE: if (start) begin
        error_d     = 1'b0;
        win_d       = '0;
        last_win_d  = WIN_BITS'(nwin - 1'b1);
        last_syms_d = VS_W'(len_ext - (nwin - 1'b1) * (LEN_BITS+1)'(SYMBOLS));
        if (block_len == '0) state_d = DONE;
        else if (nwin > (LEN_BITS+1)'(MAX_WINDOWS)) error_d = 1'b1;
        else state_d = FETCH;
      end
      FETCH:     state_d = WAIT_DATA;
      WAIT_DATA: state_d = mem_rd_valid ? ISSUE : WAIT_DATA;
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        cnt_d = cnt_q + 1'b1;
        // a result arriving on the final count still wins over the timeout
        if (mp_out_valid) state_d = WRITE;
        else if (cnt_q == CNT_W'(MAX_LATENCY - 1)) begin
          error_d = 1'b1;
          state_d = ERROR;
        end
      end
      WRITE: begin
        state_d = (win_q == last_win_q) ? DONE : FETCH;
        win_d   = (win_q == last_win_q) ? win_q : win_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      error_d = error_q;
    end
    busy_d  = state_d != IDLE;
    done_d  = state_q == DONE && !abort;
    rd_en_d = state_q == FETCH && !abort;
    iss_d   = state_q == ISSUE && !abort;
    wr_en_d = state_q == WRITE && !abort;
    addr_d  = state_q == IDLE ? '0 : win_q;
    vs_d    = state_q == IDLE ? '0 : (win_q == last_win_q ? last_syms_q : VS_W'(SYMBOLS));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= '0;
      last_win_q  <= '0;
      last_syms_q <= '0;
      cnt_q       <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      iss_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      vs_q        <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_win_q  <= last_win_d;
      last_syms_q <= last_syms_d;
      cnt_q       <= cnt_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      iss_q       <= iss_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      vs_q        <= vs_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = addr_q;
  assign stage_load  = mem_rd_valid && state_q == WAIT_DATA;
  assign mp_in_valid = iss_q;
  assign llr_wr_en   = wr_en_q;
  assign llr_wr_addr = addr_q;
  assign valid_syms  = vs_q;
endmodule

// File: tb/tb_max_product_window_sched.sv
// tb_max_product_window_sched: randomized-latency memory/datapath responders checked against a window-sequence model
module tb_max_product_window_sched;
  localparam int SYM = 4, WB = 8, LB = 11, MAXW = 256;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [LB-1:0] block_len = '0;
  logic busy, done, error, mem_rd_en, stage_load, mp_in_valid, llr_wr_en;
  logic [WB-1:0] mem_rd_addr, llr_wr_addr;
  logic [2:0] valid_syms;
  logic mem_v = 1'b0, spur_mem = 1'b0, dp_v = 1'b0, spur_mp = 1'b0;
  logic mem_rd_valid, mp_out_valid;
  int ncomp = 0, nfail = 0;
  int mem_lat = 2, dp_lat = 10, withhold = -1, mcnt = 0, dcnt = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, iss_cyc = 0, err_cyc = 0;
  bit err_prev = 1'b0, busy_seen = 1'b0;
  int ev_q[$], exp_q[$];

  assign mem_rd_valid = mem_v | spur_mem;
  assign mp_out_valid = dp_v | spur_mp;

  max_product_window_sched #(.SYMBOLS(SYM), .MAX_WINDOWS(MAXW), .WIN_BITS(WB), .LEN_BITS(LB), .MAX_LATENCY(64)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .block_len(block_len),
    .busy(busy), .done(done), .error(error), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .stage_load(stage_load), .mp_in_valid(mp_in_valid),
    .mp_out_valid(mp_out_valid), .llr_wr_en(llr_wr_en), .llr_wr_addr(llr_wr_addr), .valid_syms(valid_syms)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  // metric memory: data valid mem_lat cycles after the read request
  initial forever begin
    @(negedge clk);
    mem_v = (mcnt == 1);
    if (mcnt > 0) mcnt--;
    if (mem_rd_en) mcnt = mem_lat;
  end

  // datapath: result dp_lat cycles after the issue pulse, unless that window is withheld
  initial forever begin
    @(negedge clk);
    dp_v = (dcnt == 1);
    if (dcnt > 0) dcnt--;
    if (mp_in_valid && int'(mem_rd_addr) != withhold) dcnt = dp_lat;
  end

  always @(negedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      if (mem_rd_en) ev_q.push_back(1*4096 + int'(valid_syms)*256 + int'(mem_rd_addr));
      if (stage_load) ev_q.push_back(2*4096 + int'(valid_syms)*256 + int'(mem_rd_addr));
      if (mp_in_valid) begin
        ev_q.push_back(3*4096 + int'(valid_syms)*256 + int'(mem_rd_addr));
        iss_cyc = cyc;
      end
      if (llr_wr_en) ev_q.push_back(4*4096 + int'(valid_syms)*256 + int'(llr_wr_addr));
      if (done) begin
        ev_q.push_back(5*4096);
        done_cyc = cyc;
      end
      if (busy) busy_seen = 1'b1;
      if (start && !busy) start_cyc = cyc;
      if (error && !err_prev) err_cyc = cyc;
    end
    err_prev = error;
  end

  // expected event stream: read, stage, issue, write per window, then done; cut stops after the issue of that window
  function automatic void build(input int len, input int cut);
    int nwin;
    exp_q.delete();
    if (len > MAXW*SYM) return;
    if (len == 0) begin
      exp_q.push_back(5*4096);
      return;
    end
    nwin = (len + SYM - 1) / SYM;
    for (int w = 0; w < nwin; w++) begin
      int vs, b;
      vs = (w == nwin - 1) ? len - SYM*(nwin - 1) : SYM;
      b = vs*256 + w;
      exp_q.push_back(1*4096 + b);
      exp_q.push_back(2*4096 + b);
      exp_q.push_back(3*4096 + b);
      if (w == cut) return;
      exp_q.push_back(4*4096 + b);
    end
    exp_q.push_back(5*4096);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ev(input string tag, input int kind, input int addr);
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if ((kind == 0 ? mem_rd_en : mp_in_valid) && int'(mem_rd_addr) == addr) break;
    end
    chk(tag, i < 500, 1);
  endtask

  // mode: 0 plain, 1 withhold result of window cut, 2 abort at issue of window cut, 3 spurious inputs
  task automatic run_block(input int len, input int mlat, input int dlat, input int mode, input int cut, input logic exp_err);
    int i;
    mem_lat = mlat;
    dp_lat = dlat;
    withhold = (mode == 1) ? cut : -1;
    build(len, cut);
    @(negedge clk);
    ev_q.delete();
    busy_seen = 1'b0;
    start = 1'b1;
    block_len = LB'(len);
    @(negedge clk);
    start = 1'b0;
    if (mode == 2) begin
      wait_ev("abort_wait", 1, cut);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy_low", busy, 0);
      chk("abort_no_write", llr_wr_en, 0);
    end
    if (mode == 3) begin
      wait_ev("spur_wait_rd", 0, 0);
      spur_mp = 1'b1;
      start = 1'b1;
      block_len = LB'(1);
      @(negedge clk);
      spur_mp = 1'b0;
      start = 1'b0;
      wait_ev("spur_wait_iss", 1, 0);
      spur_mem = 1'b1;
      @(negedge clk);
      spur_mem = 1'b0;
    end
    for (i = 0; i < 3000 && busy; i++) @(negedge clk);
    chk("block_finish", i < 3000, 1);
    repeat (80) @(negedge clk);
    #2;
    chk($sformatf("len%0d_ev_count", len), ev_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < ev_q.size(); k++)
      chk($sformatf("len%0d_ev%0d", len, k), ev_q[k], exp_q[k]);
    chk($sformatf("len%0d_error", len), error, exp_err);
    chk($sformatf("len%0d_busy_seen", len), busy_seen, len <= MAXW*SYM);
    chk($sformatf("len%0d_busy_end", len), busy, 0);
    withhold = -1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, error, mem_rd_en, mem_rd_addr, stage_load, mp_in_valid, llr_wr_en, llr_wr_addr, valid_syms}, 0);
    reset = 1'b0;
    run_block(16, 2, 10, 0, -1, 1'b0);
    run_block(6, $urandom_range(1, 6), $urandom_range(1, 30), 0, -1, 1'b0);
    run_block(0, 2, 10, 0, -1, 1'b0);
    chk("len0_done_latency", done_cyc - start_cyc, 2);
    run_block(8, 2, 10, 1, 1, 1'b1);
    chk("timeout_latency", err_cyc - iss_cyc, 64);
    run_block(4, 2, 10, 0, -1, 1'b0);
    run_block(4, 1, 63, 0, -1, 1'b0);
    run_block(4, 1, 64, 0, 0, 1'b1);
    chk("timeout64_latency", err_cyc - iss_cyc, 64);
    run_block(1025, 2, 10, 0, -1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_clears_error", error, 0);
    run_block(12, 3, 7, 3, -1, 1'b0);
    run_block(16, 2, 10, 2, 2, 1'b0);
    run_block(5, 2, 10, 0, -1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      int l;
      l = $urandom_range(1, 40);
      run_block(l, $urandom_range(1, 6), $urandom_range(1, 40), 0, -1, 1'b0);
    end
    @(negedge clk);
    start = 1'b1;
    block_len = LB'(16);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midblock_reset_busy", busy, 0);
    chk("midblock_reset_strobes", {mem_rd_en, mp_in_valid, llr_wr_en, done}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
